axi_cache_arbiter: RTL and testbench

Shares the core's single AXI master port between the icache and dcache bridge interfaces (`rd_req/rd_type/rd_addr/rd_rdy/ret_*` and `wr_req/.../wr_rdy`). It sits between the two caches and the top-level AXI pins. It converts each accepted cache request into one AXI read or write burst. It allows one read and one write transaction in flight at the same time, and the dcache wins read arbitration.

---
 rtl/axi_cache_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_axi_cache_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_cache_arbiter.sv
// Shares one AXI master between the icache/dcache bridges: one read (dcache
// has priority) and one write burst may be in flight at the same time.
module axi_cache_arbiter #(
    parameter logic [3:0] RD_ID_I = 4'd0,
    parameter logic [3:0] RD_ID_D = 4'd1,
    parameter logic [3:0] WR_ID   = 4'd1
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         i_rd_req,
    input  logic [2:0]   i_rd_type,
    input  logic [31:0]  i_rd_addr,
    output logic         i_rd_rdy,
    output logic         i_ret_valid,
    output logic         i_ret_last,
    output logic [31:0]  i_ret_data,
    input  logic         d_rd_req,
    input  logic [2:0]   d_rd_type,
    input  logic [31:0]  d_rd_addr,
    output logic         d_rd_rdy,
    output logic         d_ret_valid,
    output logic         d_ret_last,
    output logic [31:0]  d_ret_data,
    input  logic         d_wr_req,
    input  logic [2:0]   d_wr_type,
    input  logic [31:0]  d_wr_addr,
    input  logic [3:0]   d_wr_wstrb,
    input  logic [127:0] d_wr_data,
    output logic         d_wr_rdy,
    output logic [3:0]   arid,
    output logic [31:0]  araddr,
    output logic [7:0]   arlen,
    output logic [2:0]   arsize,
    output logic [1:0]   arburst,
    output logic [1:0]   arlock,
    output logic [3:0]   arcache,
    output logic [2:0]   arprot,
    output logic         arvalid,
    input  logic         arready,
    input  logic [3:0]   rid,
    input  logic [31:0]  rdata,
    input  logic [1:0]   rresp,
    input  logic         rlast,
    input  logic         rvalid,
    output logic         rready,
    output logic [3:0]   awid,
    output logic [31:0]  awaddr,
    output logic [7:0]   awlen,
    output logic [2:0]   awsize,
    output logic [1:0]   awburst,
    output logic [1:0]   awlock,
    output logic [3:0]   awcache,
    output logic [2:0]   awprot,
    output logic         awvalid,
    input  logic         awready,
    output logic [3:0]   wid,
    output logic [31:0]  wdata,
    output logic [3:0]   wstrb,
    output logic         wlast,
    output logic         wvalid,
    input  logic         wready,
    input  logic [3:0]   bid,
    input  logic [1:0]   bresp,
    input  logic         bvalid,
    output logic         bready
);
    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} w_state_t;

    r_state_t       r_state, r_next;
    w_state_t       w_state, w_next;
    logic           r_own_d;
    logic [31:0]    r_addr;
    logic [2:0]     r_type;
    logic [31:0]    w_addr;
    logic [2:0]     w_type;
    logic [3:0]     w_strb;
    logic [127:0]   w_data;
    logic [1:0]     w_beat;
    logic           aw_done, w_done;
    logic           d_acc, i_acc, r_line, w_line, aw_hs, w_hs;
    logic           unused_ok;

    assign unused_ok = ^{rid, rresp, bid, bresp};

    // A dcache read may not overtake a pending or same-cycle dcache write.
    assign d_rd_rdy = (r_state == R_IDLE) && (w_state == W_IDLE) && !d_wr_req;
    assign i_rd_rdy = (r_state == R_IDLE) && !(d_rd_req && d_rd_rdy);
    assign d_acc    = d_rd_req && d_rd_rdy;
    assign i_acc    = i_rd_req && i_rd_rdy;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_state <= R_IDLE;
        else          r_state <= r_next;
    end

    always_comb begin
        r_next  = r_state;
        arvalid = 1'b0;
        rready  = 1'b0;
        unique case (r_state)
            R_IDLE: if (d_acc || i_acc) r_next = R_AR;
            R_AR: begin
                arvalid = 1'b1;
                if (arready) r_next = R_DATA;
            end
            R_DATA: begin
                rready = 1'b1;
                if (rvalid && rlast) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_own_d <= 1'b0;
            r_addr  <= '0;
            r_type  <= '0;
        end else if (d_acc) begin
            r_own_d <= 1'b1;
            r_addr  <= d_rd_addr;
            r_type  <= d_rd_type;
        end else if (i_acc) begin
            r_own_d <= 1'b0;
            r_addr  <= i_rd_addr;
            r_type  <= i_rd_type;
        end
    end

    assign r_line  = (r_type == 3'd4);
    assign arid    = r_own_d ? RD_ID_D : RD_ID_I;
    assign araddr  = r_addr;
    assign arlen   = r_line ? 8'd3 : 8'd0;
    assign arsize  = r_line ? 3'd2 : {1'b0, r_type[1:0]};
    assign arburst = 2'b01;
    assign arlock  = '0;
    assign arcache = '0;
    assign arprot  = '0;

    assign i_ret_valid = rready && !r_own_d && rvalid;
    assign i_ret_last  = rready && !r_own_d && rlast;
    assign i_ret_data  = (rready && !r_own_d) ? rdata : '0;
    assign d_ret_valid = rready && r_own_d && rvalid;
    assign d_ret_last  = rready && r_own_d && rlast;
    assign d_ret_data  = (rready && r_own_d) ? rdata : '0;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) w_state <= W_IDLE;
        else          w_state <= w_next;
    end

    // AW and W complete independently; leave W_XFER once both are done.
    always_comb begin
        w_next   = w_state;
        d_wr_rdy = 1'b0;
        awvalid  = 1'b0;
        wvalid   = 1'b0;
        bready   = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                d_wr_rdy = 1'b1;
                if (d_wr_req) w_next = W_XFER;
            end
            W_XFER: begin
                awvalid = !aw_done;
                wvalid  = !w_done;
                if ((aw_done || aw_hs) && (w_done || (w_hs && wlast))) w_next = W_RESP;
            end
            W_RESP: begin
                bready = 1'b1;
                if (bvalid) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_addr  <= '0;
            w_type  <= '0;
            w_strb  <= '0;
            w_data  <= '0;
            w_beat  <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (w_state == W_IDLE) begin
            if (d_wr_req) begin
                w_addr  <= d_wr_addr;
                w_type  <= d_wr_type;
                w_strb  <= d_wr_wstrb;
                w_data  <= d_wr_data;
                w_beat  <= '0;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
        end else if (w_state == W_XFER) begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs) begin
                if (wlast) w_done <= 1'b1;
                else       w_beat <= w_beat + 2'd1;
            end
        end
    end

    assign w_line  = (w_type == 3'd4);
    assign awid    = WR_ID;
    assign awaddr  = w_addr;
    assign awlen   = w_line ? 8'd3 : 8'd0;
    assign awsize  = w_line ? 3'd2 : {1'b0, w_type[1:0]};
    assign awburst = 2'b01;
    assign awlock  = '0;
    assign awcache = '0;
    assign awprot  = '0;
    assign wid     = WR_ID;
    assign wdata   = w_data[{w_beat, 5'd0} +: 32];
    assign wstrb   = w_line ? 4'hF : w_strb;
    assign wlast   = (w_beat == awlen[1:0]);

endmodule

// File: tb/tb_axi_cache_arbiter.sv
// Directed bench for axi_cache_arbiter: reactive AXI slave, expectation
// queues filled at stimulus time, and a negedge monitor that pops and compares.
module tb_axi_cache_arbiter;
    logic         aclk = 1'b0;
    logic         aresetn;
    logic         i_rd_req, d_rd_req, d_wr_req;
    logic [2:0]   i_rd_type, d_rd_type, d_wr_type;
    logic [31:0]  i_rd_addr, d_rd_addr, d_wr_addr;
    logic [3:0]   d_wr_wstrb;
    logic [127:0] d_wr_data;
    logic         i_rd_rdy, d_rd_rdy, d_wr_rdy;
    logic         i_ret_valid, i_ret_last, d_ret_valid, d_ret_last;
    logic [31:0]  i_ret_data, d_ret_data;
    logic [3:0]   arid, arcache, awid, awcache, wid, wstrb;
    logic [31:0]  araddr, awaddr, wdata, rdata;
    logic [7:0]   arlen, awlen;
    logic [2:0]   arsize, arprot, awsize, awprot;
    logic [1:0]   arburst, arlock, awburst, awlock;
    logic         arvalid, arready, rlast, rvalid, rready;
    logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [3:0]   rid = 4'd0, bid = 4'd0;
    logic [1:0]   rresp = 2'd0, bresp = 2'd0;

    axi_cache_arbiter #(.RD_ID_I(4'd0), .RD_ID_D(4'd1), .WR_ID(4'd1)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr), .i_rd_rdy(i_rd_rdy),
        .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last), .i_ret_data(i_ret_data),
        .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr), .d_rd_rdy(d_rd_rdy),
        .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last), .d_ret_data(d_ret_data),
        .d_wr_req(d_wr_req), .d_wr_type(d_wr_type), .d_wr_addr(d_wr_addr),
        .d_wr_wstrb(d_wr_wstrb), .d_wr_data(d_wr_data), .d_wr_rdy(d_wr_rdy),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 aclk = ~aclk;

    int n_pass = 0, n_total = 0;
    int cyc = 0, n_aw = 0, d_last_cyc = -10, b_cyc = -10;
    int ar_stall = 0, aw_stall = 0;
    logic [57:0] exp_ar[$], exp_aw[$];
    logic [36:0] exp_w[$];
    logic [32:0] exp_i[$], exp_d[$];

    always @(posedge aclk) cyc++;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    endtask

    function automatic logic [57:0] addr_vec(input logic [3:0] id, input logic [31:0] a,
                                             input logic [7:0] len, input logic [2:0] size);
        return {id, a, len, size, 2'b01, 2'b00, 4'h0, 3'h0};
    endfunction

    // Reactive slave: sample handshakes mid-cycle, update drives just after the edge.
    initial begin
        bit ar_hs, r_hs, aw_hs, wl_hs, b_hs, rs_busy, ws_aw, ws_w;
        logic [31:0] s_addr, rs_addr;
        logic [7:0] s_len, rs_len;
        int rs_beat, ar_wait, aw_wait;
        arready = 0; rvalid = 0; rlast = 0; rdata = 0; awready = 0; wready = 1; bvalid = 0;
        rs_busy = 0; ws_aw = 0; ws_w = 0; rs_beat = 0; ar_wait = 0; aw_wait = 0;
        rs_addr = 0; rs_len = 0;
        forever begin
            @(negedge aclk);
            ar_hs = arvalid & arready; r_hs = rvalid & rready;
            aw_hs = awvalid & awready; wl_hs = wvalid & wready & wlast; b_hs = bvalid & bready;
            s_addr = araddr; s_len = arlen;
            @(posedge aclk); #1;
            if (!aresetn) begin
                rs_busy = 0; rvalid = 0; rlast = 0; rdata = 0; arready = 0; ar_wait = 0;
                ws_aw = 0; ws_w = 0; bvalid = 0; awready = 0; aw_wait = 0;
            end else begin
                if (r_hs) begin
                    if (rs_beat == int'(rs_len)) rs_busy = 0;
                    else rs_beat++;
                end
                if (ar_hs) begin rs_busy = 1; rs_addr = s_addr; rs_len = s_len; rs_beat = 0; end
                if (arvalid && !rs_busy && !ar_hs) begin
                    if (ar_wait >= ar_stall) arready = 1; else ar_wait++;
                end else begin arready = 0; ar_wait = 0; end
                rvalid = rs_busy;
                rlast  = rs_busy && (rs_beat == int'(rs_len));
                rdata  = rs_busy ? rs_addr + rs_beat : 32'd0;
                if (aw_hs) ws_aw = 1;
                if (wl_hs) ws_w = 1;
                if (b_hs) begin bvalid = 0; ws_aw = 0; ws_w = 0; end
                else if (ws_aw && ws_w) bvalid = 1;
                if (awvalid && !ws_aw && !aw_hs) begin
                    if (aw_wait >= aw_stall) awready = 1; else aw_wait++;
                end else begin awready = 0; aw_wait = 0; end
            end
        end
    end

    // Monitor: every handshake / return beat pops its expected entry.
    initial forever begin
        @(negedge aclk);
        if (arvalid && arready) begin
            if (exp_ar.size() == 0) begin n_total++; $display("FAIL ar_extra: got %0h, required none", araddr); end
            else check("ar", {arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot}, exp_ar.pop_front());
        end
        if (awvalid && awready) begin
            n_aw++;
            if (exp_aw.size() == 0) begin n_total++; $display("FAIL aw_extra: got %0h, required none", awaddr); end
            else check("aw", {awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot}, exp_aw.pop_front());
        end
        if (wvalid && wready) begin
            if (exp_w.size() == 0) begin n_total++; $display("FAIL w_extra: got %0h, required none", wdata); end
            else check("w", {wdata, wstrb, wlast}, exp_w.pop_front());
        end
        if (bvalid && bready) b_cyc = cyc;
        if (i_ret_valid) begin
            check("d_ret_quiet", {d_ret_valid, d_ret_last, d_ret_data}, 0);
            if (exp_i.size() == 0) begin n_total++; $display("FAIL i_ret_extra: got %0h, required none", i_ret_data); end
            else check("i_ret", {i_ret_data, i_ret_last}, exp_i.pop_front());
        end
        if (d_ret_valid) begin
            check("i_ret_quiet", {i_ret_valid, i_ret_last, i_ret_data}, 0);
            if (d_ret_last) d_last_cyc = cyc;
            if (exp_d.size() == 0) begin n_total++; $display("FAIL d_ret_extra: got %0h, required none", d_ret_data); end
            else check("d_ret", {d_ret_data, d_ret_last}, exp_d.pop_front());
        end
    end

    task automatic rd_issue(input bit is_d, input logic [2:0] t, input logic [31:0] a);
        bit ok = 0;
        @(posedge aclk); #1;
        if (is_d) begin d_rd_req = 1; d_rd_type = t; d_rd_addr = a; end
        else      begin i_rd_req = 1; i_rd_type = t; i_rd_addr = a; end
        for (int k = 0; k < 50; k++) begin
            @(negedge aclk);
            if (is_d ? d_rd_rdy : i_rd_rdy) begin ok = 1; break; end
        end
        @(posedge aclk); #1;
        d_rd_req = 0; i_rd_req = 0;
        check("rd_accept", ok, 1);
        check("arvalid_t1", arvalid, 1);
    endtask

    task automatic wr_issue(input logic [2:0] t, input logic [31:0] a, input logic [3:0] s,
                            input logic [127:0] d);
        bit ok = 0;
        @(posedge aclk); #1;
        d_wr_req = 1; d_wr_type = t; d_wr_addr = a; d_wr_wstrb = s; d_wr_data = d;
        for (int k = 0; k < 50; k++) begin
            @(negedge aclk);
            if (d_wr_rdy) begin ok = 1; break; end
        end
        @(posedge aclk); #1;
        d_wr_req = 0;
        check("wr_accept", ok, 1);
        check("aw_w_t1", {awvalid, wvalid, d_wr_rdy}, 3'b110);
    endtask

    task automatic drain(input string name);
        int unsigned left;
        for (int k = 0; k < 200; k++) begin
            @(negedge aclk);
            left = exp_ar.size() + exp_aw.size() + exp_w.size() + exp_i.size() + exp_d.size();
            if (left == 0 && i_rd_rdy && d_wr_rdy) break;
        end
        left = exp_ar.size() + exp_aw.size() + exp_w.size() + exp_i.size() + exp_d.size();
        check(name, {left, !i_rd_rdy, !d_wr_rdy}, 0);
    endtask

    initial begin
        bit got, early, conc, lowok, bdone;
        int i_cyc, d_cyc, aw_before, cnt;
        aresetn = 0; i_rd_req = 0; d_rd_req = 0; d_wr_req = 0;
        i_rd_type = 0; d_rd_type = 0; d_wr_type = 0; i_rd_addr = 0; d_rd_addr = 0;
        d_wr_addr = 0; d_wr_wstrb = 0; d_wr_data = 0;

        // Reset values
        repeat (2) @(negedge aclk);
        check("reset_outs", {arvalid, awvalid, wvalid, rready, bready, i_ret_valid, i_ret_last,
                             d_ret_valid, d_ret_last, i_rd_rdy, d_wr_rdy, d_rd_rdy}, 12'b000000000111);
        d_wr_req = 1; #1;
        check("reset_drd_rdy", d_rd_rdy, 0);
        d_wr_req = 0;
        @(posedge aclk); #1 aresetn = 1;

        // Icache line read
        exp_ar.push_back(addr_vec(4'd0, 32'h1C000000, 8'd3, 3'd2));
        for (int k = 0; k < 4; k++) exp_i.push_back({32'h1C000000 + k, k == 3});
        rd_issue(0, 3'd4, 32'h1C000000);
        drain("drain_iline");

        // Dual read request: dcache first, icache right after rlast
        exp_ar.push_back(addr_vec(4'd1, 32'h00008000, 8'd0, 3'd2));
        exp_ar.push_back(addr_vec(4'd0, 32'h00002000, 8'd0, 3'd2));
        exp_d.push_back({32'h00008000, 1'b1});
        exp_i.push_back({32'h00002000, 1'b1});
        @(posedge aclk); #1;
        d_rd_req = 1; d_rd_type = 3'd2; d_rd_addr = 32'h8000;
        i_rd_req = 1; i_rd_type = 3'd2; i_rd_addr = 32'h2000;
        @(negedge aclk);
        check("dual_arb", {d_rd_rdy, i_rd_rdy}, 2'b10);
        @(posedge aclk); #1 d_rd_req = 0;
        got = 0; i_cyc = -1;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge aclk);
            if (i_rd_rdy) begin got = 1; i_cyc = cyc; end
            @(posedge aclk); #1;
            if (got) i_rd_req = 0;
        end
        i_rd_req = 0;
        check("i_after_rlast", i_cyc, d_last_cyc + 1);
        drain("drain_dual");

        // Line write with AW stalled 3 cycles
        aw_stall = 3;
        exp_aw.push_back(addr_vec(4'd1, 32'h00001000, 8'd3, 3'd2));
        exp_w.push_back({32'h88887777, 4'hF, 1'b0});
        exp_w.push_back({32'h66665555, 4'hF, 1'b0});
        exp_w.push_back({32'h22221111, 4'hF, 1'b0});
        exp_w.push_back({32'h44443333, 4'hF, 1'b1});
        wr_issue(3'd4, 32'h1000, 4'h0, 128'h44443333_22221111_66665555_88887777);
        aw_before = n_aw; early = 0; lowok = 1; bdone = 0;
        for (int k = 0; k < 40 && !bdone; k++) begin
            @(negedge aclk);
            if (bready && n_aw == aw_before) early = 1;
            if (d_wr_rdy) lowok = 0;
            if (bvalid && bready) bdone = 1;
        end
        check("bready_after_aw", early, 0);
        check("wr_rdy_low", lowok, 1);
        check("b_seen", bdone, 1);
        @(negedge aclk);
        check("wr_rdy_back", d_wr_rdy, 1);
        drain("drain_linewr");

        // Write and dcache read together; icache read runs meanwhile
        aw_stall = 4;
        exp_aw.push_back(addr_vec(4'd1, 32'h00003000, 8'd0, 3'd2));
        exp_w.push_back({32'hCAFE0001, 4'b0011, 1'b1});
        exp_ar.push_back(addr_vec(4'd0, 32'h00004000, 8'd0, 3'd2));
        exp_ar.push_back(addr_vec(4'd1, 32'h00009000, 8'd0, 3'd2));
        exp_i.push_back({32'h00004000, 1'b1});
        exp_d.push_back({32'h00009000, 1'b1});
        @(posedge aclk); #1;
        d_wr_req = 1; d_wr_type = 3'd2; d_wr_addr = 32'h3000; d_wr_wstrb = 4'b0011;
        d_wr_data = {96'h0, 32'hCAFE0001};
        d_rd_req = 1; d_rd_type = 3'd2; d_rd_addr = 32'h9000;
        @(negedge aclk);
        check("wr_vs_rd", {d_wr_rdy, d_rd_rdy}, 2'b10);
        @(posedge aclk); #1;
        d_wr_req = 0;
        i_rd_req = 1; i_rd_type = 3'd2; i_rd_addr = 32'h4000;
        got = 0; conc = 0; d_cyc = -1; b_cyc = -10;
        for (int k = 0; k < 60 && !got; k++) begin
            bit iacc;
            @(negedge aclk);
            iacc = i_rd_req && i_rd_rdy;
            if (arvalid && !d_wr_rdy) conc = 1;
            if (d_rd_rdy) begin got = 1; d_cyc = cyc; end
            @(posedge aclk); #1;
            if (iacc) i_rd_req = 0;
            if (got) d_rd_req = 0;
        end
        d_rd_req = 0; i_rd_req = 0;
        check("drd_after_b", d_cyc, b_cyc + 1);
        check("i_concurrent", conc, 1);
        drain("drain_wr_rd");

        // Byte write
        aw_stall = 0;
        exp_aw.push_back(addr_vec(4'd1, 32'h00005002, 8'd0, 3'd0));
        exp_w.push_back({32'h00AB0000, 4'b0100, 1'b1});
        wr_issue(3'd0, 32'h5002, 4'b0100, {96'h0, 32'h00AB0000});
        drain("drain_bytewr");

        // Reset during the third beat of a line read
        exp_ar.push_back(addr_vec(4'd0, 32'h1C000040, 8'd3, 3'd2));
        exp_i.push_back({32'h1C000040, 1'b0});
        exp_i.push_back({32'h1C000041, 1'b0});
        rd_issue(0, 3'd4, 32'h1C000040);
        cnt = 0;
        for (int k = 0; k < 40 && cnt < 2; k++) begin
            @(negedge aclk);
            if (i_ret_valid) cnt++;
        end
        check("beats_before_rst", cnt, 2);
        @(posedge aclk); #1 aresetn = 0;
        #1;
        check("rst_drop", {arvalid, rready, awvalid, wvalid, bready, i_ret_valid, i_ret_last,
                           d_ret_valid, d_ret_last}, 0);
        repeat (2) @(posedge aclk);
        #1 aresetn = 1;
        @(negedge aclk);
        check("rdy_after_rst", i_rd_rdy, 1);
        exp_ar.push_back(addr_vec(4'd0, 32'h1C000080, 8'd3, 3'd2));
        for (int k = 0; k < 4; k++) exp_i.push_back({32'h1C000080 + k, k == 3});
        rd_issue(0, 3'd4, 32'h1C000080);
        drain("drain_after_rst");

        repeat (3) @(posedge aclk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
